// File: rtl/par_serial_tx_pkg.sv
// rtl/par_serial_tx_pkg.sv - shared constants and state encoding for the serial link
//
// Purpose: COM/IDLE framing words and the SYNC/RUN state type, shared by the
// transmitter and the matching serial-to-parallel receiver.
// Ports: none (package).
package par_serial_tx_pkg;

  // Framing words are defined 8 bits wide; users resize them to their word width.
  localparam logic [7:0] COM_WORD  = 8'hBC;
  localparam logic [7:0] IDLE_WORD = 8'h7C;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_t;

endpackage

// File: rtl/tx_shift_reg.sv
// rtl/tx_shift_reg.sv - W-bit shift-left register with clear, load and shift controls
//
// Purpose: holds the word being serialised; the MSB is the line bit.
// Ports:
//   clk        - rising-edge clock
//   i_clear    - synchronous clear (highest priority)
//   i_load     - load i_data
//   i_shift    - shift left by one, i_shift_in enters at the LSB
//   i_shift_in - bit shifted in at the LSB
//   i_data     - parallel load value
//   o_msb      - current MSB (registered)
module tx_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic         i_shift_in,
  input  logic [W-1:0] i_data,
  output logic         o_msb
);

  logic [W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else if (i_shift) begin
      r_data <= {r_data[W-2:0], i_shift_in};
    end
  end

  assign o_msb = r_data[W-1];

endmodule

// File: rtl/par_serial_tx.sv
// rtl/par_serial_tx.sv - parallel-to-serial transmitter with COM sync burst and IDLE fill
//
// Purpose: sends SYNC_WORDS COM words after reset, then accepted data words MSB
// first, inserting IDLE words whenever no data is offered at a word boundary.
// Optional macro TX_PARITY_EN appends one even-parity bit after every word.
// Ports:
//   clk            - rising-edge clock
//   reset_L        - synchronous active-low reset
//   in_data        - word offered for transmission
//   in_valid       - in_data is valid
//   in_ready       - word accepted at this rising edge when in_valid is high
//   out_serial     - registered serial line
//   out_word_start - high while out_serial carries the MSB of a word
import par_serial_tx_pkg::*;

module par_serial_tx #(
  parameter int BITS       = 8,
  parameter int SYNC_WORDS = 4
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic [BITS-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_serial,
  output logic            out_word_start
);

`ifdef TX_PARITY_EN
  localparam int LAST = BITS;
`else
  localparam int LAST = BITS - 1;
`endif
  localparam int CNT_W = $clog2(LAST + 1);
  localparam int SC_W  = $clog2(SYNC_WORDS + 1);

  localparam logic [BITS-1:0] W_COM  = BITS'(COM_WORD);
  localparam logic [BITS-1:0] W_IDLE = BITS'(IDLE_WORD);

  logic             r_active;
  tx_state_t        r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [SC_W-1:0]  r_sync_cnt;

  logic            w_at_last;
  logic            w_in_ready;
  logic            w_clear;
  logic            w_load;
  logic            w_shift;
  logic            w_shift_in;
  logic [BITS-1:0] w_next_word;
  logic            w_msb;

  assign w_at_last  = (r_bit_cnt == CNT_W'(LAST));
  assign w_in_ready = r_active && (r_state == ST_RUN) && w_at_last;

  // The very first active edge loads a word just like a word boundary does.
  assign w_clear = ~reset_L;
  assign w_load  = reset_L && (!r_active || w_at_last);
  assign w_shift = reset_L && r_active && !w_at_last;

  always_comb begin
    w_next_word = W_IDLE;
    if (!r_active || r_state == ST_SYNC) begin
      w_next_word = W_COM;
    end else if (in_valid && w_in_ready) begin
      w_next_word = in_data;
    end
  end

`ifdef TX_PARITY_EN
  // Parity of the loaded word is shifted in behind the LSB, so it reaches the
  // MSB exactly in the extra bit slot.
  logic r_par;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_par <= 1'b0;
    end else if (w_load) begin
      r_par <= ^w_next_word;
    end
  end

  assign w_shift_in = r_par;
`else
  assign w_shift_in = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_active   <= 1'b0;
      r_state    <= ST_SYNC;
      r_bit_cnt  <= '0;
      r_sync_cnt <= '0;
    end else if (!r_active) begin
      r_active   <= 1'b1;
      r_bit_cnt  <= '0;
      r_sync_cnt <= SC_W'(1);
      if (SYNC_WORDS == 1) begin
        r_state <= ST_RUN;
      end
    end else if (!w_at_last) begin
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
    end else begin
      r_bit_cnt <= '0;
      if (r_state == ST_SYNC) begin
        r_sync_cnt <= r_sync_cnt + SC_W'(1);
        // This boundary loads the final COM word of the burst.
        if (r_sync_cnt == SC_W'(SYNC_WORDS - 1)) begin
          r_state <= ST_RUN;
        end
      end
    end
  end

  tx_shift_reg #(
    .W(BITS)
  ) u_shift (
    .clk        (clk),
    .i_clear    (w_clear),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_shift_in (w_shift_in),
    .i_data     (w_next_word),
    .o_msb      (w_msb)
  );

  assign in_ready       = w_in_ready;
  assign out_serial     = w_msb;
  assign out_word_start = r_active && (r_bit_cnt == '0);

endmodule

// File: doc/par_serial_tx.md
# par_serial_tx

Parallel-to-serial transmitter that turns a stream of BITS-wide words into a continuous one-bit line, MSB first. After reset it sends a burst of COM synchronisation words. It then sends accepted data words, and inserts IDLE words whenever no data is offered at a word boundary. It is the transmit end of the team's serial link, paired with the serial-to-parallel receiver that aligns on COM.

## Interface
- BITS, 8: word width; minimum 2.
- SYNC_WORDS, 4: number of COM words sent after reset; minimum 1.
- clk  input  1  rising-edge clock.
- reset_L  input  1  synchronous, active-low reset.
- in_data  input  BITS  word offered for transmission.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  transmitter accepts in_data at this rising edge.
- out_serial  output  1  serial line, registered.
- out_word_start  output  1  high while out_serial carries bit 0 (the MSB) of a word.

## Operation
- Internal state:
  - active flag;
  - state: SYNC or RUN;
  - BITS-wide shift register; out_serial is its MSB;
  - bit counter bit_cnt, range 0..LAST. LAST = BITS-1, or BITS when parity is compiled in;
  - SYNC word counter.
- Reset: any edge with reset_L=0 sets:
  - active=0, state=SYNC, shift register=0, bit_cnt=0, sync count=0;
  - outputs: out_serial=0, in_ready=0, out_word_start=0.
- First edge with reset_L=1: sets active=1, loads COM_WORD (8'hBC), bit_cnt=0, sync count=1.
- Edge with bit_cnt<LAST: shift left by one, bit_cnt+1.
- Edge with bit_cnt==LAST, word boundary: load the next word and set bit_cnt=0. The next word is chosen in this order:
  - SYNC: COM_WORD; sync count+1.
  - RUN with in_valid && in_ready: in_data, captured at this edge. Later changes to in_data have no effect.
  - RUN otherwise: IDLE_WORD (8'h7C).
- SYNC→RUN: state becomes RUN at the edge that loads the SYNC_WORDS-th COM word. There is no path back to SYNC except reset.
- in_ready = active && state==RUN && bit_cnt==LAST. It is decoded combinationally from registers and does not depend on in_valid.
- out_word_start = active && bit_cnt==0.
- COM_WORD and IDLE_WORD are 8 bits wide:
  - BITS>8: zero-extended on the left.
  - BITS<8: truncated to the low BITS bits.
- The stream never stalls. Every cycle after the first active edge carries exactly one bit.

## Timing
- Each word occupies exactly BITS cycles, or BITS+1 with parity.
- Edges are numbered E0 = first edge with reset_L=1. Words are loaded at E0, E(P), E(2P) and so on, where P = LAST+1.
- With defaults (P=8):
  - COM words are loaded at E0, E8, E16 and E24.
  - in_ready is first high in the cycle between E31 and E32.
  - A word accepted at E32 drives its MSB on out_serial during the cycle after E32.
- Latency from acceptance edge to MSB on the line: 1 cycle. To LSB: BITS cycles.
- Handshake: a transfer occurs only at an edge where in_valid && in_ready are both high. If in_valid is high while in_ready is low, the word is held by the source and is not consumed.
- Reset asserted mid-word: the word in flight is dropped at that edge. On release, the full SYNC sequence restarts from E0.
- Reset and in_valid in the same cycle: reset wins and no transfer occurs.

## Configuration
- TX_PARITY_EN defined:
  - LAST = BITS.
  - One even-parity bit (XOR of the loaded word) is sent after the LSB of every word, including COM and IDLE.
  - out_word_start and in_ready follow the BITS+1 period.
- TX_PARITY_EN undefined: no parity bit; the period is BITS.

## Structure
- Shared package: COM_WORD, IDLE_WORD, and the SYNC/RUN state encoding. The receiver uses the same package.
- One natural sub-module, tx_shift_reg: a BITS-wide shift register with synchronous clear, load and shift-left controls, exposing its MSB. Counters, state and handshake logic stay in par_serial_tx.

## Test plan
- Reset then release, in_valid=0: 32 cycles of 10111100 repeated four times, then 01111100 repeating. out_word_start is high every 8th cycle, starting in the cycle after E0; in_ready is low until the cycle before E32.
- in_valid=1 from release, in_data=8'hA5: first accepted at E32. out_serial after E32 reads 10100101. in_ready is high exactly once per 8 cycles.
- Back-to-back words 8'h01, 8'hFF, 8'h80 with in_valid always high: serial 00000001 11111111 10000000 with no gaps. Exactly three handshakes are counted.
- in_valid toggled so that it is low at one boundary: an IDLE word 01111100 is inserted. The held word is sent at the next boundary, unchanged.
- reset_L pulled low for one cycle while the 4th bit of 8'hA5 is on the line: out_serial=0 next cycle and in_ready=0. After release, the COM sequence restarts and A5 is not resent.
- TX_PARITY_EN defined, data 8'hA5: line reads 10111100 1 (COM, repeated ×4), then 101001010. in_ready is first high before E36.
